// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt controller core.
// Holds the FSM state type, the default channel count and rotate helpers.
package pic_pkg;

    localparam int PIC_NUM_IRQ_DEF = 8;
    localparam int PIC_MAX_IRQ     = 32;

    typedef enum logic {
        PIC_IDLE = 1'b0,
        PIC_ACK1 = 1'b1
    } pic_state_t;

    typedef logic [PIC_MAX_IRQ-1:0] pic_vec_t;

    // Rotate the low n bits of v right by sh (sh < n); bits >= n read as 0.
    function automatic pic_vec_t pic_rotr(
        input pic_vec_t   v,
        input logic [5:0] n,
        input logic [4:0] sh
    );
        pic_vec_t   r;
        logic [5:0] idx;
        r = '0;
        for (int i = 0; i < PIC_MAX_IRQ; i++) begin
            idx = 6'(i) + {1'b0, sh};
            if (idx >= n) idx = idx - n;
            if (6'(i) < n) r[i] = v[idx[4:0]];
        end
        return r;
    endfunction

    // Rotate the low n bits of v left by sh (sh < n); bits >= n read as 0.
    function automatic pic_vec_t pic_rotl(
        input pic_vec_t   v,
        input logic [5:0] n,
        input logic [4:0] sh
    );
        pic_vec_t   r;
        logic [5:0] idx;
        r = '0;
        for (int i = 0; i < PIC_MAX_IRQ; i++) begin
            idx = 6'(i) + {1'b0, sh};
            if (idx >= n) idx = idx - n;
            if (6'(i) < n) r[idx[4:0]] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_irq_if.sv
// CPU-side handshake bundle: INTA pulses, EOI commands, vector return.
// master = PIC command logic / CPU side, slave = pic_irq_core.
interface pic_irq_if #(
    parameter int ID_W = 3
) ();

    logic            inta;
    logic            eoi_valid;
    logic            eoi_specific;
    logic [ID_W-1:0] eoi_id;
    logic            int_out;
    logic            vec_valid;
    logic [ID_W-1:0] vec_id;
    logic            spurious;

    modport master (
        output inta, eoi_valid, eoi_specific, eoi_id,
        input  int_out, vec_valid, vec_id, spurious
    );

    modport slave (
        input  inta, eoi_valid, eoi_specific, eoi_id,
        output int_out, vec_valid, vec_id, spurious
    );

endinterface

// File: rtl/pic_prio_resolver.sv
// Combinational priority pick: highest is base, descending modulo NUM_IRQ.
// Returns whether any request bit is set and the winning channel id.
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = PIC_NUM_IRQ_DEF,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [ID_W-1:0]    base,
    output logic               found,
    output logic [ID_W-1:0]    id
);

    pic_vec_t        wide;
    pic_vec_t        rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    // Rotate so base sits at bit 0, take lowest set bit, map back to a channel.
    always_comb begin
        wide = '0;
        wide[NUM_IRQ-1:0] = req;
        rot   = pic_rotr(wide, 6'(NUM_IRQ), 5'(base));
        found = 1'b0;
        off   = '0;
        for (int i = PIC_MAX_IRQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, base};
        if (sum >= (ID_W+1)'(NUM_IRQ)) sum = sum - (ID_W+1)'(NUM_IRQ);
        id = sum[ID_W-1:0];
    end

endmodule

// File: rtl/pic_irq_core.sv
// 8259-style interrupt core: IRR/ISR, nested or rotating priority, INTA/EOI.
// Optional PIC_SPECIAL_MASK_EN adds the smm input (special mask mode).
module pic_irq_core
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = PIC_NUM_IRQ_DEF,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               rotate_en,
    input  logic               aeoi,
`ifdef PIC_SPECIAL_MASK_EN
    input  logic               smm,
`endif
    pic_irq_if.slave           bus,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);

    typedef logic [NUM_IRQ-1:0] vec_t;

    function automatic vec_t onehot(input logic [ID_W-1:0] k);
        vec_t v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] k);
        if (k == ID_W'(NUM_IRQ - 1)) return '0;
        return k + ID_W'(1);
    endfunction

    pic_state_t      state_q, state_d;
    vec_t            irr_q, irr_d;
    vec_t            isr_q, isr_d;
    vec_t            irq_prev_q, irq_prev_d;
    logic [ID_W-1:0] base_q, base_d;
    logic            int_out_q, int_out_d;
    logic            vec_valid_q, vec_valid_d;
    logic [ID_W-1:0] vec_id_q, vec_id_d;
    logic            spur_q, spur_d;
    logic [ID_W-1:0] cap_id_q, cap_id_d;
    logic            cap_spur_q, cap_spur_d;

    logic            hi_found;
    logic [ID_W-1:0] hi_id;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            eoi_hit;
    logic [ID_W-1:0] eoi_k;
    vec_t            eoi_clr;
    vec_t            isr_post;
    vec_t            pend;
    vec_t            blk;
    vec_t            cand_req;
    logic            cand;
    vec_t            ack_set;
    vec_t            aeoi_clr;

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_hi (
        .req   (isr_q),
        .base  (base_q),
        .found (hi_found),
        .id    (hi_id)
    );

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_win (
        .req   (cand_req),
        .base  (base_q),
        .found (win_found),
        .id    (win_id)
    );

    // EOI clears first; nesting then blocks on the post-EOI in-service set.
    always_comb begin
        eoi_hit = 1'b0;
        eoi_k   = '0;
        eoi_clr = '0;
        if (bus.eoi_valid) begin
            if (bus.eoi_specific) begin
                if (int'(bus.eoi_id) < NUM_IRQ) begin
                    if (isr_q[bus.eoi_id]) begin
                        eoi_hit = 1'b1;
                        eoi_k   = bus.eoi_id;
                    end
                end
            end else if (hi_found) begin
                eoi_hit = 1'b1;
                eoi_k   = hi_id;
            end
        end
        if (eoi_hit) eoi_clr = onehot(eoi_k);
        isr_post = isr_q & ~eoi_clr;
        pend     = irr_q & ~imr;
`ifdef PIC_SPECIAL_MASK_EN
        blk = smm ? (isr_post & ~imr) : isr_post;
`else
        blk = isr_post;
`endif
        // A pending bit wins only if it outranks every blocking ISR bit.
        cand_req = pend | blk;
    end

    // Handshake FSM, IRR/ISR update and priority rotation.
    always_comb begin
        state_d     = state_q;
        cap_id_d    = cap_id_q;
        cap_spur_d  = cap_spur_q;
        vec_valid_d = 1'b0;
        vec_id_d    = vec_id_q;
        spur_d      = 1'b0;
        ack_set     = '0;
        aeoi_clr    = '0;
        base_d      = base_q;
        irq_prev_d  = irq_in;
        cand        = win_found && pend[win_id] && !blk[win_id];
        if (rotate_en && eoi_hit) base_d = wrap_inc(eoi_k);
        unique case (state_q)
            PIC_IDLE: begin
                if (bus.inta) begin
                    state_d = PIC_ACK1;
                    if (cand) begin
                        cap_id_d   = win_id;
                        cap_spur_d = 1'b0;
                        ack_set    = onehot(win_id);
                    end else begin
                        cap_id_d   = ID_W'(NUM_IRQ - 1);
                        cap_spur_d = 1'b1;
                    end
                end
            end
            PIC_ACK1: begin
                if (bus.inta) begin
                    state_d     = PIC_IDLE;
                    vec_valid_d = 1'b1;
                    vec_id_d    = cap_id_q;
                    spur_d      = cap_spur_q;
                    if (aeoi && !cap_spur_q) begin
                        aeoi_clr = onehot(cap_id_q);
                        if (rotate_en) base_d = wrap_inc(cap_id_q);
                    end
                end
            end
            default: state_d = PIC_IDLE;
        endcase
        isr_d = (isr_post & ~aeoi_clr) | ack_set;
        if (ltim) irr_d = irq_in;
        else      irr_d = (irr_q | (irq_in & ~irq_prev_q)) & ~ack_set;
        int_out_d = cand && (state_d == PIC_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PIC_IDLE;
            irr_q       <= '0;
            isr_q       <= '0;
            irq_prev_q  <= '0;
            base_q      <= '0;
            int_out_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_id_q    <= '0;
            spur_q      <= 1'b0;
            cap_id_q    <= '0;
            cap_spur_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            irq_prev_q  <= irq_prev_d;
            base_q      <= base_d;
            int_out_q   <= int_out_d;
            vec_valid_q <= vec_valid_d;
            vec_id_q    <= vec_id_d;
            spur_q      <= spur_d;
            cap_id_q    <= cap_id_d;
            cap_spur_q  <= cap_spur_d;
        end
    end

    assign irr           = irr_q;
    assign isr           = isr_q;
    assign bus.int_out   = int_out_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.vec_id    = vec_id_q;
    assign bus.spurious  = spur_q;

endmodule

// File: tb/tb_pic_irq_core.sv
// Bench for pic_irq_core: 8-channel main instance with vector scoreboard,
// plus 16- and 12-channel instances for reset and out-of-range EOI cases.
module tb_pic_irq_core;

    typedef struct {
        logic [3:0] id;
        logic       spur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t e;

    logic        rst_a, ltim_a, rot_a, aeoi_a;
    logic [7:0]  irq_a, imr_a, irr_a, isr_a;
    logic        rst_b;
    logic [15:0] irq_b, irr_b, isr_b;
    logic        rst_c;
    logic [11:0] irq_c, irr_c, isr_c;

    pic_irq_if #(.ID_W(3)) bus_a ();
    pic_irq_if #(.ID_W(4)) bus_b ();
    pic_irq_if #(.ID_W(4)) bus_c ();

    pic_irq_core #(.NUM_IRQ(8)) dut_a (
        .clk(clk), .reset(rst_a), .irq_in(irq_a), .ltim(ltim_a),
        .imr(imr_a), .rotate_en(rot_a), .aeoi(aeoi_a),
`ifdef PIC_SPECIAL_MASK_EN
        .smm(1'b0),
`endif
        .bus(bus_a), .irr(irr_a), .isr(isr_a)
    );

    pic_irq_core #(.NUM_IRQ(16)) dut_b (
        .clk(clk), .reset(rst_b), .irq_in(irq_b), .ltim(1'b0),
        .imr(16'h0), .rotate_en(1'b0), .aeoi(1'b0),
`ifdef PIC_SPECIAL_MASK_EN
        .smm(1'b0),
`endif
        .bus(bus_b), .irr(irr_b), .isr(isr_b)
    );

    pic_irq_core #(.NUM_IRQ(12)) dut_c (
        .clk(clk), .reset(rst_c), .irq_in(irq_c), .ltim(1'b0),
        .imr(12'h0), .rotate_en(1'b0), .aeoi(1'b0),
`ifdef PIC_SPECIAL_MASK_EN
        .smm(1'b0),
`endif
        .bus(bus_c), .irr(irr_c), .isr(isr_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic inta_a();
        bus_a.inta = 1'b1;
        tick();
        bus_a.inta = 1'b0;
    endtask

    task automatic eoi_a(input logic spec, input logic [2:0] id);
        bus_a.eoi_valid    = 1'b1;
        bus_a.eoi_specific = spec;
        bus_a.eoi_id       = id;
        tick();
        bus_a.eoi_valid    = 1'b0;
    endtask

    task automatic edge_a(input logic [7:0] v);
        irq_a = v;
        tick();
        irq_a = 8'h00;
        tick();
    endtask

    task automatic push(input logic [3:0] id, input logic spur);
        exp_t x;
        x.id   = id;
        x.spur = spur;
        exp_q.push_back(x);
    endtask

    initial begin
        rst_a = 1'b1; ltim_a = 1'b0; rot_a = 1'b0; aeoi_a = 1'b0;
        irq_a = '0; imr_a = '0;
        rst_b = 1'b1; irq_b = '0;
        rst_c = 1'b1; irq_c = '0;
        bus_a.inta = 1'b0; bus_a.eoi_valid = 1'b0;
        bus_a.eoi_specific = 1'b0; bus_a.eoi_id = '0;
        bus_b.inta = 1'b0; bus_b.eoi_valid = 1'b0;
        bus_b.eoi_specific = 1'b0; bus_b.eoi_id = '0;
        bus_c.inta = 1'b0; bus_c.eoi_valid = 1'b0;
        bus_c.eoi_specific = 1'b0; bus_c.eoi_id = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus_a.vec_valid === 1'b1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL vec_a_unexpected: got id=%0d spur=%0d want none",
                                 bus_a.vec_id, bus_a.spurious);
                    end else begin
                        e = exp_q.pop_front();
                        if (4'(bus_a.vec_id) !== e.id || bus_a.spurious !== e.spur) begin
                            n_bad++;
                            $display("FAIL vec_a: got id=%0d spur=%0d want id=%0d spur=%0d",
                                     bus_a.vec_id, bus_a.spurious, e.id, e.spur);
                        end
                    end
                end
            end
        join_none

        repeat (2) tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        chk("rst_irr", 32'(irr_a), 32'h0);
        chk("rst_isr", 32'(isr_a), 32'h0);
        chk("rst_int_out", 32'(bus_a.int_out), 32'h0);
        chk("rst_vec_valid", 32'(bus_a.vec_valid), 32'h0);
        chk("rst_vec_id", 32'(bus_a.vec_id), 32'h0);
        chk("rst_spurious", 32'(bus_a.spurious), 32'h0);

        // Edge request on channel 3, full acknowledge.
        irq_a = 8'h08;
        tick();
        chk("edge_irr_set", 32'(irr_a), 32'h08);
        chk("edge_int_early", 32'(bus_a.int_out), 32'h0);
        irq_a = 8'h00;
        tick();
        chk("edge_int_out", 32'(bus_a.int_out), 32'h1);
        push(4'd3, 1'b0);
        inta_a();
        chk("ack1_isr", 32'(isr_a), 32'h08);
        chk("ack1_irr", 32'(irr_a), 32'h00);
        chk("ack1_int_low", 32'(bus_a.int_out), 32'h0);
        inta_a();
        tick();
        chk("vec_pulse_len", 32'(bus_a.vec_valid), 32'h0);
        eoi_a(1'b0, 3'd0);
        chk("eoi_clear3", 32'(isr_a), 32'h00);

        // Fully nested: isr[2] set, 5 and 1 pending -> only 1 passes.
        edge_a(8'h04);
        push(4'd2, 1'b0);
        inta_a();
        inta_a();
        edge_a(8'h22);
        chk("nest_irr", 32'(irr_a), 32'h22);
        chk("nest_int_out", 32'(bus_a.int_out), 32'h1);
        push(4'd1, 1'b0);
        inta_a();
        chk("nest_isr", 32'(isr_a), 32'h06);
        chk("nest_irr5", 32'(irr_a), 32'h20);
        inta_a();
        tick();
        chk("nest_blocked", 32'(bus_a.int_out), 32'h0);

        // Build isr=0x24 then exercise EOI variants.
        eoi_a(1'b0, 3'd0);
        chk("ns_eoi_06", 32'(isr_a), 32'h04);
        eoi_a(1'b1, 3'd2);
        chk("sp_eoi_2", 32'(isr_a), 32'h00);
        chk("irq5_now_up", 32'(bus_a.int_out), 32'h1);
        push(4'd5, 1'b0);
        inta_a();
        inta_a();
        edge_a(8'h04);
        chk("irq2_preempt", 32'(bus_a.int_out), 32'h1);
        push(4'd2, 1'b0);
        inta_a();
        inta_a();
        chk("isr_24", 32'(isr_a), 32'h24);
        eoi_a(1'b0, 3'd0);
        chk("ns_eoi_24", 32'(isr_a), 32'h20);
        eoi_a(1'b1, 3'd5);
        chk("sp_eoi_5", 32'(isr_a), 32'h00);

        // Rotation with auto-EOI.
        rot_a = 1'b1;
        aeoi_a = 1'b1;
        edge_a(8'h01);
        push(4'd0, 1'b0);
        inta_a();
        inta_a();
        chk("aeoi_isr0", 32'(isr_a), 32'h00);
        edge_a(8'h11);
        push(4'd4, 1'b0);
        inta_a();
        inta_a();
        push(4'd0, 1'b0);
        inta_a();
        inta_a();
        chk("rot_isr", 32'(isr_a), 32'h00);
        chk("rot_irr", 32'(irr_a), 32'h00);
        rot_a = 1'b0;
        aeoi_a = 1'b0;

        // Level request withdrawn before acknowledge -> spurious.
        ltim_a = 1'b1;
        irq_a = 8'h08;
        tick();
        chk("lvl_irr", 32'(irr_a), 32'h08);
        tick();
        chk("lvl_int_out", 32'(bus_a.int_out), 32'h1);
        irq_a = 8'h00;
        tick();
        chk("lvl_drop", 32'(irr_a), 32'h00);
        push(4'd7, 1'b1);
        inta_a();
        chk("spur_isr", 32'(isr_a), 32'h00);
        inta_a();
        ltim_a = 1'b0;
        push(4'd7, 1'b1);
        inta_a();
        inta_a();

        // Masked request, then mask change after capture.
        imr_a = 8'h40;
        edge_a(8'h40);
        chk("mask_irr", 32'(irr_a), 32'h40);
        chk("mask_int_low", 32'(bus_a.int_out), 32'h0);
        imr_a = 8'h00;
        tick();
        chk("unmask_int", 32'(bus_a.int_out), 32'h1);
        push(4'd6, 1'b0);
        inta_a();
        imr_a = 8'hFF;
        inta_a();
        imr_a = 8'h00;
        chk("mask_isr", 32'(isr_a), 32'h40);
        eoi_a(1'b1, 3'd6);
        chk("mask_eoi", 32'(isr_a), 32'h00);

        // 16 channels: reset between the two INTA pulses.
        irq_b = 16'h0200;
        tick();
        irq_b = 16'h0000;
        tick();
        bus_b.inta = 1'b1;
        tick();
        bus_b.inta = 1'b0;
        chk("b_isr9", 32'(isr_b), 32'h0200);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b_rst_isr", 32'(isr_b), 32'h0);
        chk("b_rst_irr", 32'(irr_b), 32'h0);
        chk("b_rst_vv", 32'(bus_b.vec_valid), 32'h0);
        tick();
        chk("b_no_vv", 32'(bus_b.vec_valid), 32'h0);
        bus_b.inta = 1'b1;
        tick();
        bus_b.inta = 1'b0;
        chk("b_idle_first", 32'(bus_b.vec_valid), 32'h0);
        bus_b.inta = 1'b1;
        tick();
        bus_b.inta = 1'b0;
        chk("b_vv", 32'(bus_b.vec_valid), 32'h1);
        chk("b_vid", 32'(bus_b.vec_id), 32'd15);
        chk("b_spur", 32'(bus_b.spurious), 32'h1);

        // 12 channels: specific EOI with id beyond range is ignored.
        irq_c = 12'h008;
        tick();
        irq_c = 12'h000;
        tick();
        bus_c.inta = 1'b1;
        repeat (2) tick();
        bus_c.inta = 1'b0;
        chk("c_isr3", 32'(isr_c), 32'h008);
        bus_c.eoi_valid = 1'b1;
        bus_c.eoi_specific = 1'b1;
        bus_c.eoi_id = 4'd13;
        tick();
        chk("c_eoi13_ign", 32'(isr_c), 32'h008);
        bus_c.eoi_id = 4'd3;
        tick();
        bus_c.eoi_valid = 1'b0;
        chk("c_eoi3", 32'(isr_c), 32'h000);

        repeat (3) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
